latch_bank_write_controller: RTL

Sequences write access to a bank of 2^ADDR_WIDTH registers, each DATA_WIDTH gated D latches (D, WE, AscSet0 clear), and shares that bank between two writers plus a bank-clear request. Because the bank is level-sensitive, the controller brackets every write so D is stable one full cycle before WE rises and one full cycle after WE falls. It sits between the bank and the two datapath sources that fill it. All outputs are registered.

---
 rtl/latch_bank_if.sv | 38 +++
 rtl/latch_bank_write_controller.sv | 124 ++++++++++++
 2 files changed

// File: rtl/latch_bank_if.sv
// Bus between the two write requesters / bank-clear source and the latch bank
// write controller, plus the controller's drive to the latch bank itself.
interface latch_bank_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
);
    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    logic                  Req0;
    logic [ADDR_WIDTH-1:0] Addr0;
    logic [DATA_WIDTH-1:0] Data0;
    logic                  Ack0;

    logic                  Req1;
    logic [ADDR_WIDTH-1:0] Addr1;
    logic [DATA_WIDTH-1:0] Data1;
    logic                  Ack1;

    logic                  ClearReq;
    logic                  ClearAck;

    logic [DATA_WIDTH-1:0] LatchD;
    logic [NUM_REGS-1:0]   LatchWE;
    logic                  LatchSet0;
    logic                  Busy;

    // Requester side: raises requests, observes acks and bank drive.
    modport master (
        output Req0, Addr0, Data0, Req1, Addr1, Data1, ClearReq,
        input  Ack0, Ack1, ClearAck, LatchD, LatchWE, LatchSet0, Busy
    );

    // Controller side.
    modport slave (
        input  Req0, Addr0, Data0, Req1, Addr1, Data1, ClearReq,
        output Ack0, Ack1, ClearAck, LatchD, LatchWE, LatchSet0, Busy
    );
endinterface

// File: rtl/latch_bank_write_controller.sv
// Brackets every write to a level-sensitive latch bank (D settles a cycle before
// and after WE) and shares the bank between two round-robin writers and a clear.
module latch_bank_write_controller #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic     Clock,
    input  logic     Reset,
    latch_bank_if.slave bus
);
    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ENABLE,
        ST_HOLD,
        ST_CLEAR
    } state_t;

    state_t                state_q, state_d;
    logic                  last_q, last_d;
    logic                  sel_q, sel_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] latch_d_q, latch_d_d;
    logic [NUM_REGS-1:0]   latch_we_q, latch_we_d;
    logic                  ack0_q, ack0_d;
    logic                  ack1_q, ack1_d;
    logic                  clear_ack_q, clear_ack_d;
    logic                  set0_q, set0_d;
    logic                  busy_q, busy_d;

    logic [NUM_REGS-1:0]   addr_onehot;
    logic                  grant1;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_dec
            assign addr_onehot[gi] = (addr_q == ADDR_WIDTH'(gi));
        end
    endgenerate

    // Requester 1 wins when alone, or when both ask and 0 was granted last.
    assign grant1 = bus.Req1 && (!bus.Req0 || !last_q);

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        latch_d_d   = latch_d_q;
        latch_we_d  = '0;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        clear_ack_d = 1'b0;
        set0_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.ClearReq) begin
                    state_d     = ST_CLEAR;
                    set0_d      = 1'b1;
                    clear_ack_d = 1'b1;
                end else if (bus.Req0 || bus.Req1) begin
                    state_d   = ST_SETUP;
                    sel_d     = grant1;
                    last_d    = grant1;
                    addr_d    = grant1 ? bus.Addr1 : bus.Addr0;
                    latch_d_d = grant1 ? bus.Data1 : bus.Data0;
                end
            end
            ST_SETUP: begin
                state_d    = ST_ENABLE;
                latch_we_d = addr_onehot;
            end
            ST_ENABLE: begin
                state_d = ST_HOLD;
                ack0_d  = !sel_q;
                ack1_d  = sel_q;
            end
            ST_HOLD:  state_d = ST_IDLE;
            ST_CLEAR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Reset holds AscSet0 high so the bank is cleared for as long as Reset is held.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            sel_q       <= 1'b0;
            addr_q      <= '0;
            latch_d_q   <= '0;
            latch_we_q  <= '0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            clear_ack_q <= 1'b0;
            set0_q      <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            latch_d_q   <= latch_d_d;
            latch_we_q  <= latch_we_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            clear_ack_q <= clear_ack_d;
            set0_q      <= set0_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.LatchD    = latch_d_q;
    assign bus.LatchWE   = latch_we_q;
    assign bus.Ack0      = ack0_q;
    assign bus.Ack1      = ack1_q;
    assign bus.ClearAck  = clear_ack_q;
    assign bus.LatchSet0 = set0_q;
    assign bus.Busy      = busy_q;
endmodule
